// File: rtl/lvds_link_sched.sv
// rtl/lvds_link_sched.sv - round-robin LVDS command link scheduler, one transaction in flight
// Define LVDS_SCHED_CAL_EN to compile in the post-reset link calibration sequence.
module lvds_link_sched #(
  parameter int NREQ       = 4,
  parameter int TIMEOUT    = 96,
  parameter int CAL_PASSES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [56*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 err,
  output logic [31:0]          rdata,
  output logic                 tx_valid,
  output logic [55:0]          tx_data,
  input  logic                 rx_valid,
  input  logic [31:0]          rx_data,
  output logic                 link_up,
  output logic [7:0]           cal_errors
);

  localparam int LW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(CAL_PASSES + 1);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("lvds_link_sched: NREQ must be 2..8");
  end
  if (TIMEOUT < 1 || CAL_PASSES < 1 || PW < 1) begin : g_bad_cfg
    $error("lvds_link_sched: TIMEOUT and CAL_PASSES must be positive");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT     = 3'd2
`ifdef LVDS_SCHED_CAL_EN
    ,
    CAL_SEND = 3'd3,
    CAL_WAIT = 3'd4
`endif
  } state_t;

`ifdef LVDS_SCHED_CAL_EN
  localparam state_t RESET_STATE = CAL_SEND;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [LW-1:0]     grant_q, grant_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [55:0]       tx_data_q, tx_data_d;
  logic              link_up_q, link_up_d;
`ifdef LVDS_SCHED_CAL_EN
  logic [PW-1:0]     pass_q, pass_d;
  logic [7:0]        cal_seq_q, cal_seq_d;
  logic [7:0]        cal_err_q, cal_err_d;
`endif

  logic              found;
  logic [LW-1:0]     gidx;
  logic              timed_out;

  function automatic logic [LW-1:0] rr_index(input logic [LW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return LW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest requester after last wins.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_index(last_q, k)]) begin
        found = 1'b1;
        gidx  = rr_index(last_q, k);
      end
    end
  end

  assign timed_out = (cnt_q == TW'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    ack_d      = '0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
`ifdef LVDS_SCHED_CAL_EN
    link_up_d  = link_up_q;
    pass_d     = pass_q;
    cal_seq_d  = cal_seq_q;
    cal_err_d  = cal_err_q;
`else
    link_up_d  = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (link_up_q && found) begin
          grant_d   = gidx;
          tx_data_d = req_data[56*int'(gidx) +: 56];
          state_d   = SEND;
        end
      end
      SEND: begin
        tx_valid_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + TW'(1);
        if (rx_valid) begin
          rdata_d         = rx_data;
          ack_d[grant_q]  = 1'b1;
          last_d          = grant_q;
          state_d         = IDLE;
        end else if (timed_out) begin
          rdata_d         = 32'hFFFF_FFFF;
          ack_d[grant_q]  = 1'b1;
          err_d           = 1'b1;
`ifdef LVDS_SCHED_CAL_EN
          link_up_d       = 1'b0;
          pass_d          = '0;
          state_d         = CAL_SEND;
`else
          state_d         = IDLE;
`endif
        end
      end
`ifdef LVDS_SCHED_CAL_EN
      CAL_SEND: begin
        tx_valid_d = 1'b1;
        tx_data_d  = {8'h00, 7'h0, 1'b1, 8'h00, 16'hA5C3, 8'h00, cal_seq_q};
        cal_seq_d  = cal_seq_q + 8'd1;
        cnt_d      = '0;
        state_d    = CAL_WAIT;
      end
      CAL_WAIT: begin
        cnt_d = cnt_q + TW'(1);
        // The echo is checked against the frame still held on tx_data.
        if (rx_valid && rx_data == tx_data_q[31:0]) begin
          if (pass_q == PW'(CAL_PASSES - 1)) begin
            pass_d    = '0;
            link_up_d = 1'b1;
            state_d   = IDLE;
          end else begin
            pass_d  = pass_q + PW'(1);
            state_d = CAL_SEND;
          end
        end else if (rx_valid || timed_out) begin
          pass_d = '0;
          if (cal_err_q != 8'hFF) cal_err_d = cal_err_q + 8'd1;
          state_d = CAL_SEND;
        end
      end
`endif
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      last_q     <= LW'(NREQ - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      link_up_q  <= 1'b0;
`ifdef LVDS_SCHED_CAL_EN
      pass_q     <= '0;
      cal_seq_q  <= '0;
      cal_err_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      link_up_q  <= link_up_d;
`ifdef LVDS_SCHED_CAL_EN
      pass_q     <= pass_d;
      cal_seq_q  <= cal_seq_d;
      cal_err_q  <= cal_err_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign link_up  = link_up_q;
`ifdef LVDS_SCHED_CAL_EN
  assign cal_errors = cal_err_q;
`else
  assign cal_errors = '0;
`endif

endmodule

// File: doc/lvds_link_sched.md
# lvds_link_sched

Host-side scheduler for the serial LVDS command link: it sequences link calibration after reset, then shares the link between `NREQ` requesters with round-robin arbitration. It keeps one transaction in flight at a time. Each transaction is a 56-bit frame out, then a 32-bit response back, with a timeout. It sits in the `clock_2x` domain between the requesters and the host's `lvds_tx`/`lvds_rx` pair.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 96: cycles to wait for `rx_valid` after `tx_valid`.
- `CAL_PASSES`, 4: consecutive good calibration echoes needed for link up.

Ports:
- `clock`  in  1  link clock (the `clock_2x` domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  request, one bit per requester.
- `req_data`  in  56*NREQ  frame for requester i, at bits `[56*i+55:56*i]`.
- `ack`  out  NREQ  one-cycle completion pulse for requester i.
- `err`  out  1  qualifies `ack`; 1 = timeout.
- `rdata`  out  32  response word, valid while `ack` is nonzero.
- `tx_valid`  out  1  one-cycle frame strobe to the transmitter.
- `tx_data`  out  56  frame to the transmitter.
- `rx_valid`  in  1  response strobe from the receiver.
- `rx_data`  in  32  response word.
- `link_up`  out  1  calibration passed; requests are served.
- `cal_errors`  out  8  calibration mismatch/timeout count, saturating.

## Operation
- States: `CAL_SEND`, `CAL_WAIT`, `IDLE`, `SEND`, `WAIT`. Reset enters `CAL_SEND`.
- `CAL_SEND`:
  - Drive `tx_data = {8'h00, 7'h0, 1'b1, 8'h00, pat}` with `tx_valid` = 1 for one cycle.
  - `pat = {16'hA5C3, 8'h00, cal_seq}`, where `cal_seq` is an 8-bit counter that increments per calibration frame.
  - Go to `CAL_WAIT`.
- `CAL_WAIT`:
  - `rx_valid` with `rx_data == pat`: pass count +1. If it reaches `CAL_PASSES`, set `link_up` and go to `IDLE`; otherwise go to `CAL_SEND`.
  - `rx_valid` with a mismatch, or timeout: clear the pass count, increment `cal_errors` (saturating at 255), go to `CAL_SEND`.
- `IDLE` (only while `link_up` = 1):
  - Grant the first asserted `req` at or after index `last+1` (mod `NREQ`).
  - Latch that requester's `req_data` into `tx_data`, record the grant index, go to `SEND`.
- `SEND`: `tx_valid` = 1 for one cycle, then go to `WAIT`.
- `WAIT`:
  - `rx_valid`: `rdata` <= `rx_data`, pulse `ack[g]` with `err` = 0, set `last` = g, go to `IDLE`.
  - Timeout: `rdata` <= 32'hFFFFFFFF, pulse `ack[g]` with `err` = 1, clear `link_up`, clear the pass count, go to `CAL_SEND`.
- A requester holds `req` until its `ack`. Dropping `req` before grant withdraws it. After grant, `req` and `req_data` are ignored until `ack`.
- Frames with `req_data[55:48] == 0` are forwarded unmodified; the target treats them as calibration.
- `rx_valid` outside `CAL_WAIT`/`WAIT` is ignored.
- If `rx_valid` and timeout expiry occur in the same cycle, `rx_valid` wins.

## Timing
- Reset values:
  - `ack` = 0, `err` = 0, `rdata` = 0
  - `tx_valid` = 0, `tx_data` = 0
  - `link_up` = 0, `cal_errors` = 0
  - `last` = NREQ-1, `cal_seq` = 0, pass count = 0
- All outputs are registered.
- `req` sampled in `IDLE` at cycle N → `tx_valid` at N+2 (grant at N+1, `SEND` at N+2).
- `rx_valid` at cycle M → `ack`/`rdata` at M+1. The next grant is evaluated in `IDLE` at M+1, so the earliest next `tx_valid` is at M+3.
- Timeout counter:
  - Cleared on entry to `WAIT`/`CAL_WAIT`, increments every cycle.
  - Expires when it reaches `TIMEOUT`, which is the `TIMEOUT`-th cycle after `tx_valid`.
  - Width is `$clog2(TIMEOUT+1)`.
- Reset asserted mid-transaction: immediate return to reset values; no `ack` is issued for the aborted transaction.
- `cal_seq` wraps 255 → 0.

## Configuration
- `LVDS_SCHED_CAL_EN` defined:
  - Calibration states are compiled in; behaviour is as above.
- `LVDS_SCHED_CAL_EN` undefined:
  - `CAL_SEND`/`CAL_WAIT` are removed and reset enters `IDLE`.
  - `link_up` is 1 from the first cycle after reset release; `cal_errors` is tied to 0.
  - Timeout still gives `ack` with `err` = 1 and `rdata` = FFFFFFFF, then returns to `IDLE`; `link_up` stays 1.

## Test plan
- Calibration (macro on):
  - Stimulus: loopback model echoes `rx_data = tx_data[31:0]` 40 cycles after each `tx_valid`.
  - Required: exactly 4 frames, the first being 56'h00_0001_00_A5C3_0000, `link_up` rising 1 cycle after the 4th echo, `cal_errors` = 0.
- Calibration fault:
  - Stimulus: the model corrupts echo 2 (XOR 1).
  - Required: `cal_errors` = 1, `link_up` after 6 total frames, the last with `cal_seq` = 5.
- Round-robin:
  - Stimulus: `req` = 4'b1111 held, each requester's data = 56'h10+i, responses = 32'h100+i.
  - Required: grant order 0,1,2,3,0, each `ack` with the matching `rdata`, and `tx_valid` 2 cycles after `IDLE`.
- Timeout:
  - Stimulus: no response to a requester-2 frame.
  - Required: `ack[2]` with `err` = 1 and `rdata` = FFFFFFFF exactly 97 cycles after `tx_valid`, then `link_up` = 0 and a new calibration frame.
- Edges:
  - `rx_valid` on the expiry cycle → `err` = 0.
  - `reset_n` low during `WAIT` → no `ack`, all outputs at reset values.
  - `rx_valid` while in `IDLE` → ignored.
